// File: rtl/trace_term_pkg.sv
// trace_term_pkg: shared constants, FSM state type and the core-ID width
// helper for the trace termination collector.
//   NOP_OPC / NOP_EXIT / NOP_PUTC : l.nop opcode and simulation-control codes
//   state_t                       : global collector state (RUN, DRAIN, DONE)
//   cid_width(n)                  : bits needed to name one of n cores (min 1)
package trace_term_pkg;

    localparam logic [7:0]  NOP_OPC  = 8'h15;
    localparam logic [15:0] NOP_EXIT = 16'h0001;
    localparam logic [15:0] NOP_PUTC = 16'h0004;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int cid_width(input int n);
        int w;
        w = $clog2(n);
        if (w < 1) w = 1;
        return w;
    endfunction

endpackage

// File: rtl/trace_term_core.sv
// trace_term_core: per-core slice of the trace monitor.
// Keeps a shadow copy of r3, decodes the simulation-control l.nop codes and
// holds at most one pending console character until the arbiter drains it.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   valid        : retire strobe
//   insn         : retired instruction
//   wben, wbreg,
//   wbdata       : register write-back of the retiring instruction
//   drain        : arbiter takes the held character this cycle
//   r3           : registered r3 shadow
//   exit_pulse   : combinational, l.nop exit retired this cycle
//   hold_valid   : holding register occupied
//   hold_data    : held character
//   drop         : combinational, putchar lost because the holder is busy
module trace_term_core
    import trace_term_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [31:0] insn,
    input  logic        wben,
    input  logic [4:0]  wbreg,
    input  logic [31:0] wbdata,
    input  logic        drain,
    output logic [31:0] r3,
    output logic        exit_pulse,
    output logic        hold_valid,
    output logic [7:0]  hold_data,
    output logic        drop
);

    logic is_nop;
    logic putc_pulse;
    logic unused_insn;

    assign is_nop     = valid && (insn[31:24] == NOP_OPC);
    assign exit_pulse = is_nop && (insn[15:0] == NOP_EXIT);
    assign putc_pulse = is_nop && (insn[15:0] == NOP_PUTC);
    // A busy holder only accepts a new character if it is drained this cycle.
    assign drop       = putc_pulse && hold_valid && !drain;
    assign unused_insn = ^insn[23:16];

    // The l.nop decode uses the registered value, so a write-back retired in
    // the same cycle is not observed by the decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r3 <= '0;
        end else if (valid && wben && (wbreg == 5'd3)) begin
            r3 <= wbdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else if (putc_pulse) begin
            if (!drop) begin
                hold_valid <= 1'b1;
                hold_data  <= r3[7:0];
            end
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/trace_term_collector.sv
// trace_term_collector: multi-core retire-trace monitor.
// Tracks r3 per core, collects exit status, and streams putchar characters
// tagged with their core ID through a show-ahead FIFO.
// Optional watchdog: define TRACE_TERM_WATCHDOG_EN to enable the idle
// timeout; otherwise timeout is tied low and WDOG_CYCLES is ignored.
// Handshake: a character transfers on a clock edge where char_valid and
// char_ready are both high; char_data/char_core are stable while char_valid
// is high and char_ready is low.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   trace_valid/insn/wben/
//   trace_wbreg/wbdata          : per-core retire trace, core i in slice i
//   char_valid/ready/data/core  : console character stream
//   term_vec                    : sticky per-core terminated flags
//   all_done                    : DONE reached through termination and drain
//   exit_code, fail             : first nonzero exit status
//   overflow                    : sticky, a character was dropped
//   timeout                     : sticky watchdog expiry
//   fsm_state                   : current global state (state_t encoding)
module trace_term_collector
    import trace_term_pkg::*;
#(
    parameter int NUM_CORES   = 9,
    parameter int FIFO_DEPTH  = 16,
    parameter int WDOG_CYCLES = 1000000,
    localparam int CID_W      = cid_width(NUM_CORES)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CORES-1:0]      trace_valid,
    input  logic [32*NUM_CORES-1:0]   trace_insn,
    input  logic [NUM_CORES-1:0]      trace_wben,
    input  logic [5*NUM_CORES-1:0]    trace_wbreg,
    input  logic [32*NUM_CORES-1:0]   trace_wbdata,
    output logic                      char_valid,
    input  logic                      char_ready,
    output logic [7:0]                char_data,
    output logic [CID_W-1:0]          char_core,
    output logic [NUM_CORES-1:0]      term_vec,
    output logic                      all_done,
    output logic [31:0]               exit_code,
    output logic                      fail,
    output logic                      overflow,
    output logic                      timeout,
    output logic [1:0]                fsm_state
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int SW = CID_W + 1;
    localparam int FW = 8 + CID_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Per-core slices
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] exit_vec;
    logic [NUM_CORES-1:0] hold_valid;
    logic [NUM_CORES-1:0] drop_vec;
    logic [NUM_CORES-1:0] drain_vec;
    logic [31:0]          r3_arr    [NUM_CORES];
    logic [7:0]           hold_data [NUM_CORES];

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        trace_term_core u_core (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid      (trace_valid[i]),
            .insn       (trace_insn[32*i +: 32]),
            .wben       (trace_wben[i]),
            .wbreg      (trace_wbreg[5*i +: 5]),
            .wbdata     (trace_wbdata[32*i +: 32]),
            .drain      (drain_vec[i]),
            .r3         (r3_arr[i]),
            .exit_pulse (exit_vec[i]),
            .hold_valid (hold_valid[i]),
            .hold_data  (hold_data[i]),
            .drop       (drop_vec[i])
        );
    end

    // ------------------------------------------------------------------
    // Character FIFO (show-ahead)
    // ------------------------------------------------------------------
    logic [FW-1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             pop;
    logic             can_push;
    logic             push;

    assign full     = (count == FULL_CNT);
    assign pop      = char_valid && char_ready;
    // A pop in the same cycle frees the slot for the push.
    assign can_push = !full || pop;

    assign char_valid = (count != '0);
    assign char_data  = char_valid ? mem[rd_ptr][7:0]    : '0;
    assign char_core  = char_valid ? mem[rd_ptr][FW-1:8] : '0;

    // ------------------------------------------------------------------
    // Round-robin arbiter: scan from rr_ptr upward with wrap-around
    // ------------------------------------------------------------------
    logic [CID_W-1:0] rr_ptr;
    logic [CID_W-1:0] grant_idx;
    logic             grant_any;
    logic [SW-1:0]    scan;

    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = '0;
        drain_vec = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            scan = {1'b0, rr_ptr} + SW'(k);
            if (scan >= SW'(NUM_CORES)) scan = scan - SW'(NUM_CORES);
            if (!grant_any && hold_valid[scan[CID_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = scan[CID_W-1:0];
            end
        end
        if (!can_push) grant_any = 1'b0;
        if (grant_any) drain_vec[grant_idx] = 1'b1;
    end

    assign push = grant_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == CID_W'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {grant_idx, hold_data[grant_idx]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
    state_t state;
    logic   wdog_hit;
    logic   timeout_q;

`ifdef TRACE_TERM_WATCHDOG_EN
    localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
    logic [31:0] wdog_cnt;

    assign wdog_hit = (state != DONE) && !timeout_q && (wdog_cnt == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdog_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (|trace_valid) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_LAST) begin
                wdog_cnt <= wdog_cnt + 1'b1;
            end
            if (wdog_hit) timeout_q <= 1'b1;
        end
    end
`else
    logic unused_wdog;
    assign unused_wdog = (WDOG_CYCLES == 0);
    assign wdog_hit    = 1'b0;
    assign timeout_q   = 1'b0;
`endif

    assign timeout = timeout_q;

    // ------------------------------------------------------------------
    // Exit aggregation
    // ------------------------------------------------------------------
    logic [NUM_CORES-1:0] exit_ok;
    logic                 fail_set;
    logic [31:0]          code_set;

    // Descending scan so the lowest-index nonzero exit ends up selected.
    always_comb begin
        exit_ok  = exit_vec & ~term_vec & {NUM_CORES{state != DONE}};
        fail_set = 1'b0;
        code_set = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (exit_ok[i] && (r3_arr[i] != '0)) begin
                fail_set = 1'b1;
                code_set = r3_arr[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            term_vec  <= '0;
            fail      <= 1'b0;
            exit_code <= '0;
            overflow  <= 1'b0;
        end else begin
            term_vec <= term_vec | exit_ok;
            if (!fail && fail_set) begin
                fail      <= 1'b1;
                exit_code <= code_set;
            end
            if (|drop_vec) overflow <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Global FSM
    // ------------------------------------------------------------------
    logic drain_empty;
    assign drain_empty = !(|hold_valid) && (count == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            all_done <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (wdog_hit)        state <= DONE;
                    else if (&term_vec)  state <= DRAIN;
                end
                DRAIN: begin
                    if (wdog_hit) begin
                        state <= DONE;
                    end else if (drain_empty) begin
                        state    <= DONE;
                        all_done <= 1'b1;
                    end
                end
                DONE:    state <= DONE;
                default: state <= RUN;
            endcase
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_trace_term_collector.sv
module tb_trace_term_collector;
    import trace_term_pkg::*;

    localparam int N     = 9;
    localparam int DEPTH = 4;
    localparam int WD    = 100;
    localparam int CW    = cid_width(N);

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]      trace_valid;
    logic [32*N-1:0]   trace_insn;
    logic [N-1:0]      trace_wben;
    logic [5*N-1:0]    trace_wbreg;
    logic [32*N-1:0]   trace_wbdata;
    logic              char_valid;
    logic              char_ready;
    logic [7:0]        char_data;
    logic [CW-1:0]     char_core;
    logic [N-1:0]      term_vec;
    logic              all_done;
    logic [31:0]       exit_code;
    logic              fail;
    logic              overflow;
    logic              timeout;
    logic [1:0]        fsm_state;

    trace_term_collector #(
        .NUM_CORES   (N),
        .FIFO_DEPTH  (DEPTH),
        .WDOG_CYCLES (WD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trace_valid  (trace_valid),
        .trace_insn   (trace_insn),
        .trace_wben   (trace_wben),
        .trace_wbreg  (trace_wbreg),
        .trace_wbdata (trace_wbdata),
        .char_valid   (char_valid),
        .char_ready   (char_ready),
        .char_data    (char_data),
        .char_core    (char_core),
        .term_vec     (term_vec),
        .all_done     (all_done),
        .exit_code    (exit_code),
        .fail         (fail),
        .overflow     (overflow),
        .timeout      (timeout),
        .fsm_state    (fsm_state)
    );

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q [N][$];
    int          pop_log[$];
    logic [31:0] r3_m [N];
    logic [N-1:0] term_m;
    logic        fail_m;
    logic [31:0] code_m;
    bit          expect_drop [N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < N; c++) begin
            exp_q[c].delete();
            r3_m[c] = '0;
            expect_drop[c] = 1'b0;
        end
        pop_log.delete();
        term_m = '0;
        fail_m = 1'b0;
        code_m = '0;
    endtask

    // Applies the rules of the monitor to the inputs about to be clocked in:
    // l.nop decode uses r3 as it stood before this retire, r3 updates after.
    task automatic model_apply();
        logic [31:0] insn;
        for (int c = 0; c < N; c++) begin
            insn = trace_insn[32*c +: 32];
            if (trace_valid[c] && insn[31:24] == 8'h15) begin
                if (insn[15:0] == 16'h0004 && !expect_drop[c])
                    exp_q[c].push_back(r3_m[c][7:0]);
                if (insn[15:0] == 16'h0001 && !term_m[c]) begin
                    term_m[c] = 1'b1;
                    if (!fail_m && r3_m[c] != 0) begin
                        fail_m = 1'b1;
                        code_m = r3_m[c];
                    end
                end
            end
            expect_drop[c] = 1'b0;
        end
        for (int c = 0; c < N; c++)
            if (trace_valid[c] && trace_wben[c] && trace_wbreg[5*c +: 5] == 5'd3)
                r3_m[c] = trace_wbdata[32*c +: 32];
    endtask

    // Monitor: every accepted character must be the oldest outstanding one
    // from its core.
    always @(negedge clk) begin
        if (rst_n && char_valid && char_ready) begin
            tests++;
            if (int'(char_core) >= N) begin
                fails++;
                $display("FAIL mon_core_range: got %0d, expected < %0d", char_core, N);
            end else if (exp_q[char_core].size() == 0) begin
                fails++;
                $display("FAIL mon_unexpected: got core %0d data %0h, expected nothing", char_core, char_data);
            end else begin
                logic [7:0] e;
                e = exp_q[char_core].pop_front();
                if (e !== char_data) begin
                    fails++;
                    $display("FAIL mon_data: core %0d got %0h, expected %0h", char_core, char_data, e);
                end
            end
            pop_log.push_back(int'(char_core));
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic clear_inputs();
        trace_valid  = '0;
        trace_insn   = '0;
        trace_wben   = '0;
        trace_wbreg  = '0;
        trace_wbdata = '0;
    endtask

    task automatic put_wr(input int c, input logic [31:0] d);
        trace_valid[c]          = 1'b1;
        trace_insn[32*c +: 32]  = 32'hE000_0000;
        trace_wben[c]           = 1'b1;
        trace_wbreg[5*c +: 5]   = 5'd3;
        trace_wbdata[32*c +: 32] = d;
    endtask

    task automatic put_nop(input int c, input logic [15:0] k);
        trace_valid[c]         = 1'b1;
        trace_insn[32*c +: 32] = {8'h15, 8'h00, k};
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        char_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic int outstanding();
        int t = 0;
        for (int c = 0; c < N; c++) t += exp_q[c].size();
        return t;
    endfunction

    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while ((outstanding() != 0 || char_valid) && n < budget) begin
            tick();
            n++;
        end
        check(name, (n < budget) ? 1 : 0, 1);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int last_putc [N];

    initial begin
        clear_inputs();
        char_ready = 1'b0;
        model_clear();

        // Reset state
        do_reset();
        check("rst_char_valid", char_valid, 0);
        check("rst_char_data",  char_data, 0);
        check("rst_char_core",  char_core, 0);
        check("rst_term_vec",   term_vec, 0);
        check("rst_all_done",   all_done, 0);
        check("rst_exit_code",  exit_code, 0);
        check("rst_fail",       fail, 0);
        check("rst_overflow",   overflow, 0);
        check("rst_timeout",    timeout, 0);
        check("rst_state",      fsm_state, RUN);

        // A: single putchar latency and pop
        put_wr(2, 32'h41);
        tick();
        put_nop(2, NOP_PUTC);
        tick();
        check("a_valid_1cyc", char_valid, 0);
        tick();
        check("a_valid_2cyc", char_valid, 1);
        check("a_data",       char_data, 8'h41);
        check("a_core",       char_core, 2);
        char_ready = 1'b1;
        tick();
        check("a_valid_after_pop", char_valid, 0);
        check("a_queue_empty", outstanding(), 0);

        // B: simultaneous putchars land in round-robin order from core 0
        do_reset();
        put_wr(0, 32'h61);
        put_wr(1, 32'h62);
        put_wr(3, 32'h63);
        tick();
        put_nop(0, NOP_PUTC);
        put_nop(1, NOP_PUTC);
        put_nop(3, NOP_PUTC);
        tick();
        repeat (5) tick();
        check("b_overflow", overflow, 0);
        check("b_head_core", char_core, 0);
        check("b_head_data", char_data, 8'h61);
        pop_log.delete();
        char_ready = 1'b1;
        repeat (3) tick();
        check("b_pop_count", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            check("b_order0", pop_log[0], 0);
            check("b_order1", pop_log[1], 1);
            check("b_order2", pop_log[2], 3);
        end
        check("b_empty", char_valid, 0);

        // C: fill FIFO, one char waits in the holder, the next is dropped
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            put_wr(1, 32'h30 + i);
            tick();
            put_nop(1, NOP_PUTC);
            tick();
            tick();
            tick();
        end
        check("c_full_head", char_data, 8'h30);
        put_wr(1, 32'h58);
        tick();
        put_nop(1, NOP_PUTC);
        tick();
        tick();
        check("c_no_overflow_yet", overflow, 0);
        put_wr(1, 32'h59);
        tick();
        expect_drop[1] = 1'b1;
        put_nop(1, NOP_PUTC);
        tick();
        check("c_overflow", overflow, 1);
        check("c_head_unchanged", char_data, 8'h30);
        check("c_head_core", char_core, 1);
        char_ready = 1'b1;
        wait_drained("c_drain_bound", 30);
        check("c_overflow_sticky", overflow, 1);

        // Random traffic against the model
        do_reset();
        for (int c = 0; c < N; c++) last_putc[c] = -1000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            char_ready = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < N; c++) begin
                int ch;
                logic [31:0] r;
                ch = $urandom_range(0, 9);
                if (ch >= 4 && ch <= 6) begin
                    put_wr(c, $urandom);
                    if ($urandom_range(0, 1) == 0)
                        trace_wbreg[5*c +: 5] = 5'($urandom_range(0, 31));
                end else if (ch == 7 && (cyc - last_putc[c]) >= 64) begin
                    if ($urandom_range(0, 1) == 0) put_wr(c, $urandom);
                    put_nop(c, NOP_PUTC);
                    last_putc[c] = cyc;
                end else if (ch == 8) begin
                    r = $urandom;
                    if (r[31:24] == 8'h15) r[31:24] = 8'h16;
                    trace_valid[c]         = 1'b1;
                    trace_insn[32*c +: 32] = r;
                end else if (ch == 9) begin
                    put_nop(c, 16'h0002);
                end
            end
            tick();
        end
        char_ready = 1'b1;
        wait_drained("rand_drain_bound", 100);
        check("rand_outstanding", outstanding(), 0);
        check("rand_overflow", overflow, 0);
        check("rand_term_vec", term_vec, 0);
        check("rand_fail", fail, 0);
        check("rand_state", fsm_state, RUN);

        // D: exits, priority, ignored repeat exit, drain to DONE
        do_reset();
        put_wr(0, 32'h78);
        put_wr(1, 32'h79);
        tick();
        put_nop(0, NOP_PUTC);
        put_nop(1, NOP_PUTC);
        tick();
        for (int c = 0; c < N; c++) put_wr(c, (c == 4) ? 32'h7 : (c == 6) ? 32'h9 : 32'h0);
        tick();
        put_nop(0, NOP_EXIT);
        tick();
        check("d_term_first", term_vec, term_m);
        check("d_fail_zero_exit", fail, fail_m);
        check("d_code_zero_exit", exit_code, code_m);
        put_wr(0, 32'h5);
        tick();
        for (int c = 0; c < N; c++) put_nop(c, NOP_EXIT);
        tick();
        check("d_term_all", term_vec, term_m);
        check("d_fail", fail, fail_m);
        check("d_code", exit_code, code_m);
        check("d_code_const", exit_code, 32'h7);
        tick();
        check("d_state_drain", fsm_state, DRAIN);
        check("d_not_done", all_done, 0);
        repeat (3) tick();
        check("d_hold_done", all_done, 0);
        char_ready = 1'b1;
        begin
            int n = 0;
            while (char_valid && n < 20) begin
                tick();
                n++;
            end
            check("d_drain_bound", (n < 20) ? 1 : 0, 1);
        end
        check("d_done_not_yet", all_done, 0);
        tick();
        check("d_all_done", all_done, 1);
        check("d_state_done", fsm_state, DONE);
        check("d_timeout", timeout, 0);
        check("d_outstanding", outstanding(), 0);

        // E: asynchronous reset while draining
        do_reset();
        put_wr(5, 32'h7A);
        tick();
        put_nop(5, NOP_PUTC);
        tick();
        for (int c = 0; c < N; c++) put_nop(c, NOP_EXIT);
        tick();
        tick();
        tick();
        check("e_state_drain", fsm_state, DRAIN);
        check("e_fifo_busy", char_valid, 1);
        check("e_fail", fail, 1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("e_rst_char_valid", char_valid, 0);
        check("e_rst_char_data",  char_data, 0);
        check("e_rst_char_core",  char_core, 0);
        check("e_rst_term_vec",   term_vec, 0);
        check("e_rst_exit_code",  exit_code, 0);
        check("e_rst_fail",       fail, 0);
        check("e_rst_all_done",   all_done, 0);
        check("e_rst_state",      fsm_state, RUN);
        do_reset();
        tick();
        check("e_post_state", fsm_state, RUN);
        check("e_post_valid", char_valid, 0);

`ifdef TRACE_TERM_WATCHDOG_EN
        // Watchdog: idle trace from reset release
        do_reset();
        repeat (WD - 1) tick();
        check("w_timeout_early", timeout, 0);
        tick();
        check("w_timeout", timeout, 1);
        check("w_all_done", all_done, 0);
        check("w_state_done", fsm_state, DONE);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d tests", tests);
        $fatal(1, "global timeout");
    end

endmodule
